layouta_stream_ctrl: RTL and testbench
======================================

# layouta_stream_ctrl

Sequencer between the layoutA skew unit and the systolic array. On a start command it latches the feature-map dimensions m×n. It then streams the skewed map (m rows, n+m-1 diagonal columns) to the array one column per accepted beat over a valid/ready handshake, and signals completion. Rows at or above m are zeroed on the way out. Out-of-range dimensions are rejected.

## Interface

- BITS, 8, bit width of each pixel
- DIM, 32, maximum feature-map dimension; array height
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to stream a map; honoured only in IDLE
- m  in  $clog2(DIM)+1  row count, sampled on accepted start
- n  in  $clog2(DIM)+1  column count, sampled on accepted start
- skew_in  in  [BITS-1:0] [DIM-1:0][DIM*2-2:0]  layoutA output; must be held stable while busy=1
- col_valid  out  1  col_data/col_idx hold a beat
- col_ready  in  1  array accepts the beat
- col_data  out  [BITS-1:0] [DIM-1:0]  current skewed column, one pixel per array row
- col_idx  out  $clog2(DIM*2-1)  index of the current column
- col_last  out  1  current beat is column m+n-2
- busy  out  1  high from accepted start until done inclusive
- done  out  1  one-cycle pulse after the last beat transfers
- err  out  1  one-cycle pulse when start is rejected

## Operation

- States: IDLE, STREAM, DONE.
- IDLE, start=1, m and n both in 1..DIM: latch m_r=m, n_r=n, last_r=m+n-2. Load col_data from column 0 and set col_idx=0. Go to STREAM.
- IDLE, start=1, m=0, n=0, m>DIM or n>DIM: err=1 for one cycle, no latch, stay IDLE.
- STREAM: col_valid=1. A beat transfers when col_valid&col_ready.
  - On transfer with col_idx<last_r: col_idx+1, col_data reloaded from column col_idx+1.
  - On transfer with col_idx==last_r: go to DONE, col_valid drops.
  - No transfer: col_idx and col_data hold.
- DONE: done=1, busy=1, one cycle, then IDLE.
- col_data[r] = skew_in[r][col] for r<m_r, and 0 for r>=m_r.
- col_last = STREAM && col_idx==last_r. It is combinational from registered state.
- start outside IDLE is ignored: no err, no relatch.
- Arithmetic: last_r is computed at $clog2(DIM*2-1) bits. The maximum is 2·DIM-2 (62 at DIM=32), so it never overflows.
- m=n=1: a single beat, col_idx=0, col_last=1 on the first valid cycle.

## Timing

- Reset values: col_valid=0, col_data=0, col_idx=0, col_last=0, busy=0, done=0, err=0, state=IDLE, m_r=n_r=last_r=0.
- Reset mid-stream: all outputs clear immediately (async). No done pulse. The next start begins a fresh map.
- Start accepted at edge t: col_valid=1 and busy=1 from t+1.
- Each transfer at edge k presents the next column at k+1. The controller never inserts bubbles.
  - With col_ready tied high, the stream takes m+n-1 consecutive valid cycles.
  - done follows the cycle after the last transfer.
  - start to done takes m+n+1 cycles.
- col_valid never drops without a transfer in STREAM.
- col_data and col_idx are stable while col_valid=1 and col_ready=0.
- err asserts the cycle after a rejected start; busy stays 0.
- A start coinciding with done is ignored. A new start is accepted once the block is in IDLE, the earliest being the cycle after done.

## Test plan

- m=n=32, random skew_in, col_ready=1 → 63 beats with col_idx 0..62.
  - col_data[r] matches skew_in[r][col_idx] for every beat.
  - col_last only at col_idx=62.
  - done at cycle 65 after start.
- m=n=5, col_ready toggling 1,0,0,1 repeating → 9 beats, col_idx 0..8.
  - col_data/col_idx held during ready=0.
  - col_data rows 5..31 always 0.
- m=1, n=1 → a single beat col_idx=0 with col_last=1, then done the next cycle.
  - m=14, n=3 → 16 beats, last col_idx=15.
- Rejections: start with m=0, then n=33, then m=40 → err pulse one cycle after each, busy=0, col_valid=0.
  - start asserted during an m=n=14 stream is ignored: 27 beats, no err.
- Assert rst at beat 10 of m=n=32 → all outputs 0 immediately and no done pulse.
  - A subsequent start with m=n=5 streams 9 beats correctly.

Source files
------------

// File: rtl/layouta_stream_ctrl.sv
// Purpose: sequences a skewed m x n feature map from the layoutA skew unit into the systolic array, one diagonal column per beat.
// Latency: start accepted at edge t -> first column valid from t+1; done pulses the cycle after the last beat transfers.
// Backpressure: col_valid/col_ready handshake; col_data/col_idx hold while col_ready=0, and the stream never inserts bubbles.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, m, n         stream request and map dimensions (sampled only on an accepted start in IDLE)
//   skew_in             full skewed map, skew_in[row][col] is one pixel; held stable by the source while busy
//   col_valid/col_ready beat handshake toward the array
//   col_data, col_idx   current column (rows >= m zeroed) and its index
//   col_last            current beat is the final column (m+n-2)
//   busy, done, err     in-flight flag, completion pulse, rejected-start pulse
module layouta_stream_ctrl #(
    parameter int BITS = 8,
    parameter int DIM  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [$clog2(DIM):0]                  m,
    input  logic [$clog2(DIM):0]                  n,
    input  logic [DIM-1:0][DIM*2-2:0][BITS-1:0]   skew_in,
    output logic                                  col_valid,
    input  logic                                  col_ready,
    output logic [DIM-1:0][BITS-1:0]              col_data,
    output logic [$clog2(DIM*2-1)-1:0]            col_idx,
    output logic                                  col_last,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int DW   = $clog2(DIM) + 1;
    localparam int IW   = $clog2(DIM*2-1);
    localparam int NCOL = DIM*2 - 1;
    localparam logic [DW-1:0] DIM_W = DW'(DIM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state;
    // The column count only matters through last_r, so it is not kept separately.
    logic [DW-1:0]   m_r;
    logic [IW-1:0]   last_r;

    logic [IW-1:0]             sel_col;
    logic [DW-1:0]             sel_rows;
    logic [DIM-1:0][BITS-1:0]  sel_data;
    logic                      start_ok;
    logic [IW-1:0]             last_nxt;

    // Column that will be loaded at the next edge: column 0 on a start, otherwise
    // the successor of the current column. Row masking uses the incoming m on a
    // start because m_r is not latched yet.
    always_comb begin
        sel_col  = (state == IDLE) ? '0 : col_idx + 1'b1;
        sel_rows = (state == IDLE) ? m  : m_r;
        sel_data = '0;
        for (int r = 0; r < DIM; r++) begin
            // sel_col can run one past the final column on the last beat; that value is never loaded.
            if ((r < int'(sel_rows)) && (int'(sel_col) < NCOL)) begin
                sel_data[r] = skew_in[r][sel_col];
            end
        end
    end

    assign start_ok = (m != '0) && (n != '0) && (m <= DIM_W) && (n <= DIM_W);
    // Max value is 2*DIM-2, which fits in IW bits.
    assign last_nxt = IW'(m) + IW'(n) - IW'(2);

    assign col_last = (state == STREAM) && (col_idx == last_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m_r       <= '0;
            last_r    <= '0;
            col_valid <= 1'b0;
            col_data  <= '0;
            col_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            m_r       <= m;
                            last_r    <= last_nxt;
                            col_data  <= sel_data;
                            col_idx   <= '0;
                            col_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= STREAM;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (col_ready) begin
                        if (col_idx == last_r) begin
                            col_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            col_idx  <= sel_col;
                            col_data <= sel_data;
                        end
                    end
                end
                DONE: begin
                    // busy covers the done cycle, then drops as we return to IDLE.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layouta_stream_ctrl.sv
// Purpose: self-checking bench for layouta_stream_ctrl against a per-beat reference of the skewed map.
// Latency: checks first beat the cycle after start and done the cycle after the last transfer.
// Backpressure: drives col_ready always-high, in a fixed 1,0,0,1 pattern, and randomly.
module tb_layouta_stream_ctrl;

    localparam int BITS = 8;
    localparam int DIM  = 32;
    localparam int DW   = $clog2(DIM) + 1;
    localparam int IW   = $clog2(DIM*2-1);

    logic                                 clk;
    logic                                 rst;
    logic                                 start;
    logic [DW-1:0]                        m;
    logic [DW-1:0]                        n;
    logic [DIM-1:0][DIM*2-2:0][BITS-1:0]  skew;
    logic                                 col_valid;
    logic                                 col_ready;
    logic [DIM-1:0][BITS-1:0]             col_data;
    logic [IW-1:0]                        col_idx;
    logic                                 col_last;
    logic                                 busy;
    logic                                 done;
    logic                                 err;

    int tests;
    int fails;

    layouta_stream_ctrl #(.BITS(BITS), .DIM(DIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .m         (m),
        .n         (n),
        .skew_in   (skew),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .col_data  (col_data),
        .col_idx   (col_idx),
        .col_last  (col_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic randomize_map();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM*2-1; c++)
                skew[r][c] = BITS'($urandom);
    endtask

    // Runs one map from the current negedge. mode: 0 ready high, 1 pattern 1,0,0,1, 2 random.
    // poke_at: beat at which a (to-be-ignored) start is driven, -1 none.
    // abort_at: beat at which reset is pulsed, -1 none.
    // poke_done: drive a valid start during the done cycle, which must be ignored.
    task automatic stream_map(input int mm, input int nn, input int mode,
                              input int poke_at, input int abort_at, input bit poke_done);
        int total, beat, stalls, cyc, k;
        logic rdy;
        logic [DIM-1:0][BITS-1:0] exp_col;
        total = mm + nn - 1;
        beat = 0; stalls = 0; k = 0;
        randomize_map();
        m = DW'(mm); n = DW'(nn); start = 1'b1; col_ready = 1'b0;
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        for (int guard = 0; guard < 2000; guard++) begin
            if (col_valid === 1'b1) begin
                tests++;
                if (beat >= total) begin
                    fails++;
                    $display("FAIL overrun_%0dx%0d: got beat %0d, required at most %0d beats", mm, nn, beat + 1, total);
                    return;
                end
                for (int r = 0; r < DIM; r++)
                    exp_col[r] = (r < mm) ? skew[r][beat] : '0;
                tests++;
                if (col_idx !== IW'(beat)) begin
                    fails++;
                    $display("FAIL col_idx_%0dx%0d: got %0d, required %0d", mm, nn, col_idx, beat);
                end
                tests++;
                if (col_data !== exp_col) begin
                    fails++;
                    $display("FAIL col_data_%0dx%0d beat %0d: got %h, required %h", mm, nn, beat, col_data, exp_col);
                end
                tests++;
                if (col_last !== (beat == total - 1)) begin
                    fails++;
                    $display("FAIL col_last_%0dx%0d beat %0d: got %b, required %b", mm, nn, beat, col_last, beat == total - 1);
                end
                tests++;
                if ({busy, done, err} !== 3'b100) begin
                    fails++;
                    $display("FAIL flags_stream_%0dx%0d beat %0d: got busy/done/err %b, required 100", mm, nn, beat, {busy, done, err});
                end
                if (abort_at == beat) begin
                    rst = 1'b1;
                    #1;
                    tests++;
                    if ({col_valid, col_data, col_idx, col_last, busy, done, err} !== '0) begin
                        fails++;
                        $display("FAIL abort_clear: got valid %b idx %0d last %b busy %b done %b err %b data %h, required all 0",
                                 col_valid, col_idx, col_last, busy, done, err, col_data);
                    end
                    @(negedge clk);
                    rst = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        tests++;
                        if ({done, col_valid, busy} !== 3'b000) begin
                            fails++;
                            $display("FAIL abort_no_done: got done/valid/busy %b, required 000", {done, col_valid, busy});
                        end
                    end
                    return;
                end
                start = (poke_at == beat);
                if (poke_at == beat) begin
                    m = DW'(3); n = DW'(3);
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = ((k % 4) == 0) || ((k % 4) == 3);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                col_ready = rdy;
                if (rdy) beat++;
                else stalls++;
                k++;
            end else begin
                start = 1'b0;
                tests++;
                if (beat !== total) begin
                    fails++;
                    $display("FAIL valid_drop_%0dx%0d: got %0d beats, required %0d", mm, nn, beat, total);
                end
                tests++;
                if ({done, busy, err} !== 3'b110) begin
                    fails++;
                    $display("FAIL done_pulse_%0dx%0d: got done/busy/err %b, required 110", mm, nn, {done, busy, err});
                end
                tests++;
                if (cyc !== mm + nn + 1 + stalls) begin
                    fails++;
                    $display("FAIL done_cycle_%0dx%0d: got %0d, required %0d", mm, nn, cyc, mm + nn + 1 + stalls);
                end
                if (poke_done) begin
                    start = 1'b1; m = DW'(4); n = DW'(4);
                end
                @(negedge clk);
                start = 1'b0;
                tests++;
                if ({col_valid, busy, done, err} !== 4'b0000) begin
                    fails++;
                    $display("FAIL idle_after_done_%0dx%0d: got valid/busy/done/err %b, required 0000", mm, nn, {col_valid, busy, done, err});
                end
                return;
            end
            @(negedge clk);
            cyc++;
        end
        tests++;
        fails++;
        $display("FAIL timeout_%0dx%0d: got no done within 2000 cycles, required done", mm, nn);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests++;
        if ({col_valid, col_idx, col_last, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: got valid %b idx %0d last %b busy %b done %b err %b, required all 0",
                     col_valid, col_idx, col_last, busy, done, err);
        end
        tests++;
        if (col_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h, required 0", col_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({col_valid, busy, done, err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_idle: got valid/busy/done/err %b, required 0000", {col_valid, busy, done, err});
        end
    endtask

    task automatic test_full();
        stream_map(32, 32, 0, -1, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        stream_map(5, 5, 1, -1, -1, 1'b0);
    endtask

    task automatic test_small_shapes();
        stream_map(1, 1, 0, -1, -1, 1'b0);
        stream_map(14, 3, 2, -1, -1, 1'b0);
        stream_map(3, 14, 2, -1, -1, 1'b0);
    endtask

    task automatic test_reject();
        int rm [3] = '{0, 5, 40};
        int rn [3] = '{5, 33, 5};
        for (int i = 0; i < 3; i++) begin
            m = DW'(rm[i]); n = DW'(rn[i]); start = 1'b1; col_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            tests++;
            if ({err, busy, col_valid} !== 3'b100) begin
                fails++;
                $display("FAIL reject_%0dx%0d: got err/busy/valid %b, required 100", rm[i], rn[i], {err, busy, col_valid});
            end
            @(negedge clk);
            tests++;
            if ({err, busy, col_valid} !== 3'b000) begin
                fails++;
                $display("FAIL reject_pulse_%0dx%0d: got err/busy/valid %b, required 000", rm[i], rn[i], {err, busy, col_valid});
            end
        end
    endtask

    task automatic test_start_during();
        stream_map(14, 14, 0, 6, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        stream_map(2, 4, 0, -1, -1, 1'b1);
        stream_map(6, 2, 0, -1, -1, 1'b0);
    endtask

    task automatic test_abort();
        stream_map(32, 32, 0, -1, 10, 1'b0);
        stream_map(5, 5, 0, -1, -1, 1'b0);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0; start = 1'b0; m = '0; n = '0; col_ready = 1'b0; skew = '0;
        #1;
        test_reset();
        test_full();
        test_backpressure();
        test_small_shapes();
        test_reject();
        test_start_during();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
